// File: rtl/tick_sched.sv
// Multi-channel programmable tick generator with a two-cycle configuration handshake.
// Each active channel emits a one-cycle pulse every div clocks; hold freezes all phases.
module tick_sched #(
    parameter int NCH  = 4,
    parameter int DIVW = 17,
    localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            cfg_valid,
    output logic            cfg_ready,
    input  logic [CHW-1:0]  cfg_ch,
    input  logic [DIVW-1:0] cfg_div,
    input  logic            cfg_en,
    input  logic            hold,
    output logic [NCH-1:0]  tick,
    output logic [NCH-1:0]  active
);

    typedef enum logic {IDLE = 1'b0, APPLY = 1'b1} state_t;

    state_t          state_q;
    logic [CHW-1:0]  lch_q;
    logic [DIVW-1:0] ldiv_q;
    logic            len_q;

    logic [DIVW-1:0] count_q  [NCH];
    logic [DIVW-1:0] count_d  [NCH];
    logic [DIVW-1:0] reload_q [NCH];
    logic [DIVW-1:0] reload_d [NCH];
    logic [NCH-1:0]  active_q, active_d;
    logic [NCH-1:0]  tick_q, tick_d;

    logic [DIVW-1:0] div_m1;
    logic            apply_hit;

    assign cfg_ready = (state_q == IDLE);
    assign tick      = tick_q;
    assign active    = active_q;

    // A divide value of 0 behaves as 1, so the reload value is never below 0.
    assign div_m1    = (ldiv_q == '0) ? '0 : ldiv_q - DIVW'(1);
    assign apply_hit = (state_q == APPLY) && (int'(lch_q) < NCH);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            case (state_q)
                IDLE:    if (cfg_valid) state_q <= APPLY;
                APPLY:   state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (state_q == IDLE && cfg_valid) begin
            lch_q  <= cfg_ch;
            ldiv_q <= cfg_div;
            len_q  <= cfg_en;
        end
    end

    // Reconfiguration of the addressed channel takes priority over its own reload.
    always_comb begin
        active_d = active_q;
        tick_d   = '0;
        for (int i = 0; i < NCH; i++) begin
            count_d[i]  = count_q[i];
            reload_d[i] = reload_q[i];
            if (apply_hit && int'(lch_q) == i) begin
                if (len_q) begin
                    count_d[i]  = div_m1;
                    reload_d[i] = div_m1;
                    active_d[i] = 1'b1;
                end else begin
                    active_d[i] = 1'b0;
                end
            end else if (active_q[i] && !hold) begin
                if (count_q[i] == '0) begin
                    count_d[i] = reload_q[i];
                    tick_d[i]  = 1'b1;
                end else begin
                    count_d[i] = count_q[i] - DIVW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            active_q <= '0;
            tick_q   <= '0;
            for (int i = 0; i < NCH; i++) begin
                count_q[i]  <= '0;
                reload_q[i] <= '0;
            end
        end else begin
            active_q <= active_d;
            tick_q   <= tick_d;
            for (int i = 0; i < NCH; i++) begin
                count_q[i]  <= count_d[i];
                reload_q[i] <= reload_d[i];
            end
        end
    end

endmodule

// File: tb/tb_tick_sched.sv
// Bench for tick_sched: directed scenarios plus randomized traffic checked every cycle
// against an elapsed-cycles model of each channel.
module tb_tick_sched;

    localparam int NCH  = 5;
    localparam int DIVW = 17;
    localparam int CHW  = 3;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            cfg_valid = 1'b0;
    logic            cfg_ready;
    logic [CHW-1:0]  cfg_ch = '0;
    logic [DIVW-1:0] cfg_div = '0;
    logic            cfg_en = 1'b0;
    logic            hold = 1'b0;
    logic [NCH-1:0]  tick;
    logic [NCH-1:0]  active;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    tick_sched #(.NCH(NCH), .DIVW(DIVW)) dut (
        .clk(clk), .reset(reset), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_ch(cfg_ch), .cfg_div(cfg_div), .cfg_en(cfg_en), .hold(hold),
        .tick(tick), .active(active)
    );

    always #5 clk = ~clk;

    // Model: a channel ticks whenever its count of unheld edges since configuration
    // is a positive multiple of its period.
    bit m_apply = 1'b0;
    int m_lch = 0, m_ldiv = 0;
    bit m_len = 1'b0;
    bit m_act [NCH];
    bit m_tk  [NCH];
    int m_el  [NCH];
    int m_div [NCH];

    always @(posedge clk) begin
        if (reset) begin
            m_apply <= 1'b0;
            for (int i = 0; i < NCH; i++) begin
                m_act[i] <= 1'b0;
                m_tk[i]  <= 1'b0;
                m_el[i]  <= 0;
                m_div[i] <= 1;
            end
        end else begin
            for (int i = 0; i < NCH; i++) begin
                if (m_apply && m_lch < NCH && m_lch == i) begin
                    m_tk[i] <= 1'b0;
                    if (m_len) begin
                        m_act[i] <= 1'b1;
                        m_div[i] <= (m_ldiv == 0) ? 1 : m_ldiv;
                        m_el[i]  <= 0;
                    end else begin
                        m_act[i] <= 1'b0;
                    end
                end else if (m_act[i] && !hold) begin
                    m_el[i] <= m_el[i] + 1;
                    m_tk[i] <= ((m_el[i] + 1) % m_div[i]) == 0;
                end else begin
                    m_tk[i] <= 1'b0;
                end
            end
            if (m_apply) begin
                m_apply <= 1'b0;
            end else if (cfg_valid) begin
                m_apply <= 1'b1;
                m_lch   <= int'(cfg_ch);
                m_ldiv  <= int'(cfg_div);
                m_len   <= cfg_en;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            logic [NCH-1:0] et, ea;
            for (int i = 0; i < NCH; i++) begin
                et[i] = m_tk[i];
                ea[i] = m_act[i];
            end
            checks++;
            if (tick !== et) begin
                errors++;
                $display("FAIL tick_model t=%0t: got %b expected %b", $time, tick, et);
            end
            checks++;
            if (active !== ea) begin
                errors++;
                $display("FAIL active_model t=%0t: got %b expected %b", $time, active, ea);
            end
            checks++;
            if (cfg_ready !== !m_apply) begin
                errors++;
                $display("FAIL ready_model t=%0t: got %b expected %b", $time, cfg_ready, !m_apply);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s t=%0t: got %0h expected %0h", nm, $time, got, exp);
        end
    endtask

    task automatic cfg(input int ch, input int dv, input bit en);
        int n = 0;
        while (!cfg_ready && n < 4) begin
            step();
            n++;
        end
        chk("cfg_wait", {31'd0, cfg_ready}, 32'd1);
        cfg_valid = 1'b1;
        cfg_ch    = ch[CHW-1:0];
        cfg_div   = dv[DIVW-1:0];
        cfg_en    = en;
        step();
        cfg_valid = 1'b0;
        chk("cfg_busy", {31'd0, cfg_ready}, 32'd0);
        step();
    endtask

    task automatic wait_tick0();
        int n = 0;
        while (!tick[0] && n < 12) begin
            step();
            n++;
        end
        chk("wait_tick0", {31'd0, tick[0]}, 32'd1);
    endtask

    initial begin
        // Reset with a request held high
        cfg_valid = 1'b1;
        cfg_ch    = 3'd2;
        cfg_div   = 17'd5;
        cfg_en    = 1'b1;
        repeat (3) step();
        chk_en = 1'b1;
        reset     = 1'b0;
        cfg_valid = 1'b0;
        step();
        chk("rst_ready", {31'd0, cfg_ready}, 32'd1);
        chk("rst_active", {27'd0, active}, 32'd0);
        chk("rst_tick", {27'd0, tick}, 32'd0);

        // ch0 div=4
        cfg(0, 4, 1'b1);
        chk("c0_e1_tick", {31'd0, tick[0]}, 32'd0);
        chk("c0_active", {31'd0, active[0]}, 32'd1);
        for (int k = 1; k <= 8; k++) begin
            step();
            chk("c0_period", {31'd0, tick[0]}, (k % 4 == 0) ? 32'd1 : 32'd0);
        end

        // ch1 div=0 behaves as div=1
        cfg(1, 0, 1'b1);
        chk("c1_e1_tick", {31'd0, tick[1]}, 32'd0);
        step();
        chk("c1_tick_a", {31'd0, tick[1]}, 32'd1);
        step();
        chk("c1_tick_b", {31'd0, tick[1]}, 32'd1);

        // hold for 3 cycles right after a ch0 tick delays the next by 3
        wait_tick0();
        hold = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("hold_tick", {27'd0, tick}, 32'd0);
        end
        hold = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            step();
            chk("post_hold", {31'd0, tick[0]}, (k == 4) ? 32'd1 : 32'd0);
        end

        // E1 of a div=2 reconfiguration lands on ch0's count==0 edge
        step();
        step();
        cfg(0, 2, 1'b1);
        chk("reload_override", {31'd0, tick[0]}, 32'd0);
        for (int k = 1; k <= 4; k++) begin
            step();
            chk("c0_div2", {31'd0, tick[0]}, (k % 2 == 0) ? 32'd1 : 32'd0);
        end

        // invalid channel, disable, then reset during APPLY
        cfg(NCH, 3, 1'b1);
        chk("invalid_ch", {27'd0, active}, 32'h3);
        cfg(0, 4, 1'b0);
        chk("dis_active", {31'd0, active[0]}, 32'd0);
        chk("dis_tick", {31'd0, tick[0]}, 32'd0);
        for (int k = 0; k < 5; k++) begin
            step();
            chk("dis_quiet", {31'd0, tick[0]}, 32'd0);
        end
        cfg_valid = 1'b1;
        cfg_ch    = 3'd2;
        cfg_div   = 17'd3;
        cfg_en    = 1'b1;
        step();
        chk("apply_busy", {31'd0, cfg_ready}, 32'd0);
        reset = 1'b1;
        step();
        reset     = 1'b0;
        cfg_valid = 1'b0;
        step();
        chk("apply_rst_ready", {31'd0, cfg_ready}, 32'd1);
        for (int k = 0; k < 5; k++) begin
            step();
            chk("apply_rst_active", {27'd0, active}, 32'd0);
        end

        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            reset     = ($urandom_range(0, 199) == 0);
            cfg_valid = ($urandom_range(0, 2) == 0);
            cfg_ch    = 3'($urandom_range(0, 7));
            cfg_div   = 17'($urandom_range(0, 9));
            cfg_en    = ($urandom_range(0, 4) != 0);
            hold      = ($urandom_range(0, 9) == 0);
            step();
        end
        reset = 1'b0;
        cfg_valid = 1'b0;
        hold = 1'b0;
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/tick_sched.md
TICK_SCHED -- requirements
Module: tick_sched

Interface
REQ-001 SHALL have parameter NCH, default 4, number of tick channels (1..8).
REQ-002 SHALL have parameter DIVW, default 17, width of each channel divide value.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port cfg_valid  input  1  configuration request.
REQ-006 SHALL have port cfg_ready  output  1  high when a configuration request is accepted this cycle.
REQ-007 SHALL have port cfg_ch  input  $clog2(NCH) (min 1)  target channel index.
REQ-008 SHALL have port cfg_div  input  DIVW  divide value, i.e. tick period in clk cycles.
REQ-009 SHALL have port cfg_en  input  1  1 = enable channel, 0 = disable channel.
REQ-010 SHALL have port hold  input  1  global freeze of all channel counters.
REQ-011 SHALL have port tick  output  NCH  registered one-cycle pulse per channel.
REQ-012 SHALL have port active  output  NCH  registered per-channel enabled status.

Function
REQ-013 SHALL implement a two-state configuration FSM: IDLE (cfg_ready=1) and APPLY (cfg_ready=0).
REQ-014 SHALL accept a request on an edge with cfg_valid=1 in IDLE: latch cfg_ch, cfg_div and cfg_en; move to APPLY.
REQ-015 SHALL, on the edge leaving APPLY (E1), update the latched channel and return to IDLE; throughput is one configuration per 2 cycles.
REQ-016 SHALL ignore cfg_valid while in APPLY; cfg_ready SHALL be combinationally equal to (state==IDLE).
REQ-017 SHALL, at E1 with en=1, set count=div-1, reload=div-1 and active=1; tick for that channel SHALL be 0 in the following cycle.
REQ-018 SHALL treat cfg_div=0 as 1.
REQ-019 SHALL, at E1 with en=0, clear active and tick; count SHALL be held.
REQ-020 SHALL ignore cfg_ch >= NCH: no channel changes; the FSM still passes through APPLY.
REQ-021 SHALL, on each edge for each active channel with hold=0: if count==0, load count=reload and set tick=1; otherwise decrement count and set tick=0.
REQ-022 SHALL produce the first tick in the cycle following edge E1+div, and one tick every div cycles thereafter; div=1 SHALL give tick=1 every cycle.
REQ-023 SHALL, on each edge with hold=1, hold all counts and clear all ticks; counting SHALL resume from the held value when hold returns to 0.
REQ-024 SHALL let a reconfiguration at E1 override the count==0 reload for that channel: phase restarts per REQ-017 and no tick is produced.
REQ-025 SHALL let a reconfiguration of one channel leave all other channels' counts and ticks unaffected.
REQ-026 SHALL keep inactive channels at tick=0.

Reset
REQ-027 SHALL, when reset=1 at an edge, set state=IDLE and clear every count, reload, active and tick to 0.
REQ-028 SHALL give reset priority over hold and configuration; a request pending in APPLY SHALL be discarded.
REQ-029 SHALL present after reset: cfg_ready=1, tick=0, active=0.

Verification
REQ-030 SHALL verify the following directed scenarios:
- Reset with cfg_valid=1 held -> cfg_ready=1, active=0, tick=0 in the cycle after release.
- Configure ch0 with div=4, en=1 -> cfg_ready low for 1 cycle; tick[0] first high in the cycle after E1+4, then every 4 cycles; active[0]=1.
- Configure ch1 with div=0 -> tick[1] high every cycle from E1+1; ch0 phase is unchanged.
- ch0 running at div=4, hold=1 for 3 cycles -> no ticks during hold; next tick delayed exactly 3 cycles.
- Reconfigure ch0 at div=2 so that E1 coincides with count==0 -> no tick at that edge; ticks resume at E1+2, then every 2 cycles.
- Request with cfg_ch=NCH, then disable ch0, then assert reset while in APPLY -> invalid request has no effect; tick[0]/active[0] go to 0; request during reset is discarded.
